// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: coordinate width and the
// food-spawn FSM state encoding.
package snake_pkg;

   localparam int COORD_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      DRAW_X,
      DRAW_Y,
      CHECK,
      PLACE
   } spawn_state_e;

endpackage

// File: rtl/food_spawn_ctrl.sv
// Food placement controller: draws a random in-bounds cell, checks it against the
// snake body store and retries on collision. Optional macro: FOOD_SPAWN_STATS_EN.
module food_spawn_ctrl
   import snake_pkg::*;
#(
   parameter int GRID_W    = 32,
   parameter int GRID_H    = 24,
   parameter int MAX_TRIES = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               spawn_req,
   input  logic [COORD_W-1:0] rand_i,
   output logic               query_valid,
   output logic [COORD_W-1:0] query_x,
   output logic [COORD_W-1:0] query_y,
   input  logic               query_ack,
   input  logic               query_hit,
   output logic [COORD_W-1:0] food_x,
   output logic [COORD_W-1:0] food_y,
   output logic               food_valid,
   output logic               busy,
`ifdef FOOD_SPAWN_STATS_EN
   output logic [7:0]         last_tries,
   output logic [7:0]         fail_count,
`endif
   output logic               spawn_done,
   output logic               spawn_fail
);

   localparam logic [COORD_W:0] GRID_W_C = (COORD_W+1)'(GRID_W);
   localparam logic [COORD_W:0] GRID_H_C = (COORD_W+1)'(GRID_H);
   localparam logic [7:0]       MAX_C    = 8'(MAX_TRIES);

   spawn_state_e       state_q;
   logic [COORD_W-1:0] cand_x_q, cand_y_q;
   logic [COORD_W-1:0] food_x_q, food_y_q;
   logic               food_valid_q, query_valid_q, busy_q;
   logic               done_q, fail_q;
   logic [7:0]         tries_q;
   logic               in_w, in_h;
   logic [7:0]         tries_inc;

   // Zero-extend so a full 32-wide grid still compares correctly against 5-bit rand.
   assign in_w      = {1'b0, rand_i} < GRID_W_C;
   assign in_h      = {1'b0, rand_i} < GRID_H_C;
   assign tries_inc = tries_q + 8'd1;

`ifdef FOOD_SPAWN_STATS_EN
   logic [7:0] last_tries_q, fail_count_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cand_x_q      <= '0;
         cand_y_q      <= '0;
         food_x_q      <= '0;
         food_y_q      <= '0;
         food_valid_q  <= 1'b0;
         query_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         fail_q        <= 1'b0;
         tries_q       <= '0;
`ifdef FOOD_SPAWN_STATS_EN
         last_tries_q  <= '0;
         fail_count_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         fail_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (spawn_req) begin
                  food_valid_q <= 1'b0;
                  tries_q      <= '0;
                  busy_q       <= 1'b1;
                  state_q      <= DRAW_X;
               end
            end
            DRAW_X: begin
               cand_x_q <= rand_i;
               if (in_w) state_q <= DRAW_Y;
            end
            DRAW_Y: begin
               cand_y_q <= rand_i;
               if (in_h) begin
                  query_valid_q <= 1'b1;
                  state_q       <= CHECK;
               end
            end
            CHECK: begin
               if (query_ack) begin
                  query_valid_q <= 1'b0;
                  if (!query_hit) begin
                     // Food and the done pulse are registered here so they appear in PLACE.
                     food_x_q     <= cand_x_q;
                     food_y_q     <= cand_y_q;
                     food_valid_q <= 1'b1;
                     done_q       <= 1'b1;
                     state_q      <= PLACE;
`ifdef FOOD_SPAWN_STATS_EN
                     last_tries_q <= tries_q;
`endif
                  end else begin
                     tries_q <= tries_inc;
                     if (tries_inc == MAX_C) begin
                        fail_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef FOOD_SPAWN_STATS_EN
                        last_tries_q <= tries_inc;
                        if (fail_count_q != 8'hFF) fail_count_q <= fail_count_q + 8'd1;
`endif
                     end else begin
                        state_q <= DRAW_X;
                     end
                  end
               end
            end
            PLACE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign query_valid = query_valid_q;
   assign query_x     = cand_x_q;
   assign query_y     = cand_y_q;
   assign food_x      = food_x_q;
   assign food_y      = food_y_q;
   assign food_valid  = food_valid_q;
   assign busy        = busy_q;
   assign spawn_done  = done_q;
   assign spawn_fail  = fail_q;
`ifdef FOOD_SPAWN_STATS_EN
   assign last_tries  = last_tries_q;
   assign fail_count  = fail_count_q;
`endif

endmodule

// File: doc/food_spawn_ctrl.md
FOOD_SPAWN_CTRL -- requirements
Module: food_spawn_ctrl

Interface
REQ-001 SHALL have parameter GRID_W, 32, playfield width in cells, legal range 2..32.
REQ-002 SHALL have parameter GRID_H, 24, playfield height in cells, legal range 2..32.
REQ-003 SHALL have parameter MAX_TRIES, 15, collision-rejected placements allowed before giving up, range 1..255.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port spawn_req  input  1  one-cycle request for new food, e.g. on food eaten or game start.
REQ-007 SHALL have port rand  input  5  free-running pseudo-random value from the random number generator; new value every cycle.
REQ-008 SHALL have port query_valid  output  1  occupancy query to the snake-body store.
REQ-009 SHALL have port query_x / query_y  output  5 each  candidate cell under query.
REQ-010 SHALL have port query_ack  input  1  query answered this cycle.
REQ-011 SHALL have port query_hit  input  1  candidate is occupied; valid only with query_ack.
REQ-012 SHALL have port food_x / food_y  output  5 each  current food cell.
REQ-013 SHALL have port food_valid  output  1  food_x/food_y hold a placed food.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port spawn_done  output  1  one-cycle pulse on successful placement.
REQ-016 SHALL have port spawn_fail  output  1  one-cycle pulse when MAX_TRIES is exhausted.

Function
REQ-017 SHALL implement FSM states IDLE, DRAW_X, DRAW_Y, CHECK, PLACE.
REQ-018 SHALL, in IDLE with spawn_req=1, clear food_valid, clear the try counter and go to DRAW_X next cycle.
REQ-019 SHALL ignore spawn_req in any state other than IDLE; no queuing.
REQ-020 SHALL, in DRAW_X, latch rand as candidate x and go to DRAW_Y if rand < GRID_W; otherwise stay in DRAW_X and resample next cycle.
REQ-021 SHALL, in DRAW_Y, latch rand as candidate y and go to CHECK if rand < GRID_H; otherwise stay in DRAW_Y.
REQ-022 SHALL, in CHECK, hold query_valid=1 with query_x/query_y equal to the candidate, stable until the cycle query_ack=1.
REQ-023 SHALL treat query_ack in the same cycle query_valid first rises as a valid response; minimum CHECK dwell is one cycle.
REQ-024 SHALL, on query_ack with query_hit=0, go to PLACE.
REQ-025 SHALL, on query_ack with query_hit=1, increment the try counter; if the new count equals MAX_TRIES, pulse spawn_fail and go to IDLE with food_valid=0; otherwise go to DRAW_X.
REQ-026 SHALL, in PLACE, load food_x/food_y from the candidate, set food_valid=1, pulse spawn_done for that one cycle, and go to IDLE.
REQ-027 SHALL change food_x/food_y only in PLACE.
REQ-028 SHALL keep query_valid=0 outside CHECK.
REQ-029 SHALL make the try counter 8 bits wide and never wrap: the count is bounded by MAX_TRIES.
REQ-030 SHALL take exactly 4 cycles from spawn_req to spawn_done when both draws are in range on first sample, the query is acked immediately, and there is no hit.

Reset
REQ-031 SHALL, while reset=1, force state IDLE, food_x=0, food_y=0, food_valid=0, query_valid=0, query_x=0, query_y=0, busy=0, spawn_done=0, spawn_fail=0, and try counter=0.
REQ-032 SHALL abort any in-flight spawn on reset mid-operation, drop query_valid the following cycle, and produce no done or fail pulse.
REQ-033 SHALL give reset priority over spawn_req in the same cycle.

Configuration
REQ-034 SHALL, with FOOD_SPAWN_STATS_EN defined, add output last_tries (8 bits), updated to the try count at every spawn_done or spawn_fail, reset to 0, plus output fail_count (8 bits), which increments on spawn_fail and saturates at 255.
REQ-035 SHALL, without FOOD_SPAWN_STATS_EN, omit both ports and their registers; all other behaviour is identical.

Structure
REQ-036 SHALL place the FSM state enumeration and the 5-bit coordinate width constant in shared package snake_pkg.
REQ-037 SHALL be a single module with no sub-modules; the random number generator is instantiated alongside it, not inside it.

Verification
REQ-038 SHALL cover: reset, spawn_req, rand=5 then 9, immediate ack, no hit -> spawn_done at cycle 4, food=(5,9), food_valid=1.
REQ-039 SHALL cover: GRID_H=24, rand sequence x=3, y=30, 27, 12 -> DRAW_Y held 2 extra cycles, food=(3,12).
REQ-040 SHALL cover: MAX_TRIES=3, query_hit=1 on every ack -> spawn_fail pulses once after the 3rd ack, food_valid=0, busy=0 the next cycle.
REQ-041 SHALL cover: query_ack delayed 5 cycles -> query_x/query_y and query_valid stable all 5 cycles, and a spawn_req asserted during the wait is ignored.
REQ-042 SHALL cover: reset asserted in CHECK -> all outputs at reset values the next cycle, with no spawn_done.
REQ-043 SHALL cover: FOOD_SPAWN_STATS_EN with 2 hits then a miss -> last_tries=2 and fail_count=0.
